// File: rtl/instr_fetch_if.sv
// ============================================================================
// Module      : instr_fetch_if
// Description : Instruction-memory, decode-handshake and redirect signals
//               of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_if;
  logic        oImemReq;
  logic [31:0] oImemAddr;
  logic        iImemAck;
  logic [31:0] iImemRdata;
  logic        oValid;
  logic        iReady;
  logic [31:0] oInstr;
  logic [31:0] oPc;
  logic        iRedirect;
  logic [31:0] iRedirectPc;
  logic        oMisalign;

  modport master (
    output oImemReq, oImemAddr, oValid, oInstr, oPc, oMisalign,
    input  iImemAck, iImemRdata, iReady, iRedirect, iRedirectPc
  );

  modport slave (
    input  oImemReq, oImemAddr, oValid, oInstr, oPc, oMisalign,
    output iImemAck, iImemRdata, iReady, iRedirect, iRedirectPc
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module      : instr_fetch
// Description : Single-outstanding instruction fetch stage with redirect
//               handling and a one-entry output hold register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire           iClk,
  input  wire           iRstN,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      rState;
  state_t      wStateNext;
  logic [31:0] rPc;
  logic [31:0] wPcNext;
  logic [31:0] rPending;
  logic [31:0] wPendingNext;
  logic [31:0] rInstr;
  logic [31:0] wInstrNext;
  logic [31:0] rPcOut;
  logic [31:0] wPcOutNext;
  logic        rMisalign;
  logic [31:0] wTarget;

  assign wTarget = {bus.iRedirectPc[31:2], 2'b00};

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      rState <= IDLE;
    end else begin
      rState <= wStateNext;
    end
  end

  always_comb begin
    wStateNext   = rState;
    wPcNext      = rPc;
    wPendingNext = rPending;
    wInstrNext   = rInstr;
    wPcOutNext   = rPcOut;
    unique case (rState)
      IDLE: begin
        if (bus.iRedirect) begin
          wPcNext = wTarget;
        end
        wStateNext = FETCH;
      end
      FETCH: begin
        if (bus.iRedirect) begin
          if (bus.iImemAck) begin
            wPcNext = wTarget;
          end else begin
            // Request stays on the bus at the old address until it is acked.
            wPendingNext = wTarget;
            wStateNext   = DROP;
          end
        end else if (bus.iImemAck) begin
          wInstrNext = bus.iImemRdata;
          wPcOutNext = rPc;
          wPcNext    = rPc + 32'd4;
          wStateNext = HOLD;
        end
      end
      DROP: begin
        if (bus.iRedirect) begin
          wPendingNext = wTarget;
        end
        if (bus.iImemAck) begin
          wPcNext    = bus.iRedirect ? wTarget : rPending;
          wStateNext = FETCH;
        end
      end
      HOLD: begin
        if (bus.iRedirect) begin
          wPcNext    = wTarget;
          wStateNext = FETCH;
        end else if (bus.iReady) begin
          wStateNext = FETCH;
        end
      end
      default: wStateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      rPc       <= RESET_PC;
      rPending  <= 32'd0;
      rInstr    <= 32'd0;
      rPcOut    <= 32'd0;
      rMisalign <= 1'b0;
    end else begin
      rPc       <= wPcNext;
      rPending  <= wPendingNext;
      rInstr    <= wInstrNext;
      rPcOut    <= wPcOutNext;
      rMisalign <= bus.iRedirect && (bus.iRedirectPc[1:0] != 2'b00);
    end
  end

  assign bus.oImemReq  = (rState == FETCH) || (rState == DROP);
  assign bus.oImemAddr = {rPc[31:2], 2'b00};
  assign bus.oValid    = (rState == HOLD);
  assign bus.oInstr    = rInstr;
  assign bus.oPc       = rPcOut;
  assign bus.oMisalign = rMisalign;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  logic iClk;
  logic iRstN;
  int   errors;
  int   checks;

  instr_fetch_if busA ();
  instr_fetch_if busB ();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dutA (
    .iClk  (iClk),
    .iRstN (iRstN),
    .bus   (busA)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dutB (
    .iClk  (iClk),
    .iRstN (iRstN),
    .bus   (busB)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idleInputs();
    busA.iImemAck = 0; busA.iImemRdata = 0; busA.iReady = 0;
    busA.iRedirect = 0; busA.iRedirectPc = 0;
    busB.iImemAck = 0; busB.iImemRdata = 0; busB.iReady = 0;
    busB.iRedirect = 0; busB.iRedirectPc = 0;
  endtask

  task automatic test_reset();
    idleInputs();
    iRstN = 1'b0;
    #1;
    chk("rst_req",      {31'd0, busA.oImemReq},  32'd0);
    chk("rst_valid",    {31'd0, busA.oValid},    32'd0);
    chk("rst_misalign", {31'd0, busA.oMisalign}, 32'd0);
    chk("rst_instr",    busA.oInstr,             32'd0);
    chk("rst_pc",       busA.oPc,                32'd0);
    tick();
    iRstN = 1'b1;
    #1;
    chk("idle_req", {31'd0, busA.oImemReq}, 32'd0);
    tick();
    chk("first_req",  {31'd0, busA.oImemReq}, 32'd1);
    chk("first_addr", busA.oImemAddr,         32'h0);
  endtask

  task automatic test_sequence();
    busA.iImemAck = 1; busA.iImemRdata = 32'h0050_0093; busA.iReady = 1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busA.oImemReq !== 1'b1 || busA.oValid !== 1'b0 || busA.oImemAddr !== 32'(4 * i)) begin
        errors++;
        $display("FAIL seq_fetch%0d: req=%b valid=%b addr=%h expected req=1 valid=0 addr=%h",
                 i, busA.oImemReq, busA.oValid, busA.oImemAddr, 32'(4 * i));
      end
      tick();
      checks++;
      if (busA.oValid !== 1'b1 || busA.oImemReq !== 1'b0 || busA.oPc !== 32'(4 * i)
          || busA.oInstr !== 32'h0050_0093) begin
        errors++;
        $display("FAIL seq_hold%0d: valid=%b req=%b pc=%h instr=%h expected 1 0 %h 00500093",
                 i, busA.oValid, busA.oImemReq, busA.oPc, busA.oInstr, 32'(4 * i));
      end
      tick();
    end
    busA.iImemAck = 0;
  endtask

  task automatic test_backpressure();
    chk("bp_addr", busA.oImemAddr, 32'hC);
    busA.iImemAck = 1; busA.iImemRdata = 32'h1122_3344; busA.iReady = 0;
    tick();
    busA.iImemAck = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (busA.oValid !== 1'b1 || busA.oImemReq !== 1'b0 || busA.oPc !== 32'hC
          || busA.oInstr !== 32'h1122_3344) begin
        errors++;
        $display("FAIL bp_stall%0d: valid=%b req=%b pc=%h instr=%h expected 1 0 0000000c 11223344",
                 i, busA.oValid, busA.oImemReq, busA.oPc, busA.oInstr);
      end
      tick();
    end
    busA.iReady = 1;
    tick();
    chk("bp_release_valid", {31'd0, busA.oValid}, 32'd0);
    chk("bp_release_addr",  busA.oImemAddr,        32'h10);
  endtask

  task automatic test_redirect_fetch();
    busA.iRedirect = 1; busA.iRedirectPc = 32'h100;
    tick();
    busA.iRedirect = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (busA.oImemReq !== 1'b1 || busA.oImemAddr !== 32'h10 || busA.oValid !== 1'b0) begin
        errors++;
        $display("FAIL drop_wait%0d: req=%b addr=%h valid=%b expected 1 00000010 0",
                 i, busA.oImemReq, busA.oImemAddr, busA.oValid);
      end
      tick();
    end
    busA.iImemAck = 1; busA.iImemRdata = 32'hDEAD_BEEF;
    chk("drop_ack_addr", busA.oImemAddr, 32'h10);
    tick();
    busA.iImemAck = 0;
    chk("drop_done_valid", {31'd0, busA.oValid},   32'd0);
    chk("drop_done_req",   {31'd0, busA.oImemReq}, 32'd1);
    chk("drop_done_addr",  busA.oImemAddr,         32'h100);
  endtask

  task automatic test_drop_overwrite();
    busA.iRedirect = 1; busA.iRedirectPc = 32'h40;
    tick();
    busA.iRedirectPc = 32'h60;
    tick();
    busA.iRedirect = 0; busA.iImemAck = 1;
    chk("ovr_held_addr", busA.oImemAddr, 32'h100);
    tick();
    chk("ovr_last_wins", busA.oImemAddr, 32'h60);
    busA.iImemRdata = 32'h0000_0013;
    tick();
    busA.iImemAck = 0;
    chk("ovr_hold_pc",    busA.oPc,    32'h60);
    chk("ovr_hold_instr", busA.oInstr, 32'h0000_0013);
  endtask

  task automatic test_redirect_hold();
    busA.iReady = 0; busA.iRedirect = 1; busA.iRedirectPc = 32'h203;
    tick();
    busA.iRedirect = 0;
    chk("rh_valid",    {31'd0, busA.oValid},    32'd0);
    chk("rh_misalign", {31'd0, busA.oMisalign}, 32'd1);
    chk("rh_addr",     busA.oImemAddr,          32'h200);
    tick();
    chk("rh_misalign_once", {31'd0, busA.oMisalign}, 32'd0);
    chk("rh_addr_held",     busA.oImemAddr,          32'h200);
    busA.iRedirect = 1; busA.iRedirectPc = 32'h300; busA.iImemAck = 1;
    tick();
    busA.iRedirect = 0; busA.iImemAck = 0;
    chk("rack_valid", {31'd0, busA.oValid}, 32'd0);
    chk("rack_addr",  busA.oImemAddr,       32'h300);
  endtask

  task automatic test_idle_redirect();
    iRstN = 1'b0;
    tick();
    iRstN = 1'b1;
    busA.iRedirect = 1; busA.iRedirectPc = 32'h40;
    tick();
    busA.iRedirect = 0;
    chk("idle_redir_addr", busA.oImemAddr, 32'h40);
  endtask

  task automatic test_wrap();
    iRstN = 1'b0;
    tick();
    iRstN = 1'b1;
    tick();
    chk("wrap_first_addr", busB.oImemAddr, 32'hFFFF_FFFC);
    busB.iImemAck = 1; busB.iImemRdata = 32'h0000_0073; busB.iReady = 1;
    tick();
    busB.iImemAck = 0;
    chk("wrap_hold_pc", busB.oPc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_next_addr", busB.oImemAddr, 32'h0);
  endtask

  task automatic test_reset_in_drop();
    // Entry: dutA freshly out of reset, in FETCH at 0x0.
    busA.iImemAck = 1; busA.iImemRdata = 32'hCAFE_F00D; busA.iReady = 1;
    tick();
    busA.iImemAck = 0;
    tick();
    chk("rd_fetch_addr", busA.oImemAddr, 32'h4);
    busA.iRedirect = 1; busA.iRedirectPc = 32'h501;
    tick();
    busA.iRedirect = 0;
    chk("rd_misalign_pre", {31'd0, busA.oMisalign}, 32'd1);
    #2;
    iRstN = 1'b0;
    #1;
    checks++;
    if (busA.oImemReq !== 1'b0 || busA.oValid !== 1'b0 || busA.oMisalign !== 1'b0
        || busA.oInstr !== 32'd0 || busA.oPc !== 32'd0) begin
      errors++;
      $display("FAIL rd_async: req=%b valid=%b mis=%b instr=%h pc=%h expected all zero",
               busA.oImemReq, busA.oValid, busA.oMisalign, busA.oInstr, busA.oPc);
    end
    tick();
    iRstN = 1'b1;
    tick();
    chk("rd_restart_req",  {31'd0, busA.oImemReq}, 32'd1);
    chk("rd_restart_addr", busA.oImemAddr,         32'h0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_sequence();
    test_backpressure();
    test_redirect_fetch();
    test_drop_overwrite();
    test_redirect_hold();
    test_idle_redirect();
    test_wrap();
    test_reset_in_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
